// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : VLIW instruction fetch stage. Drives the bundle address to
//                the memory instruction port and queues {pc, bundle} pairs
//                in a small circular FIFO toward decode (valid/ready).
//                Supports flush-and-redirect for branches and exceptions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic [31:0]                pc_out,
  input  logic [127:0]               inst_bundle_in,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       bundle_valid,
  input  logic                       bundle_ready,
  output logic [127:0]               bundle_out,
  output logic [31:0]                bundle_pc,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int                  c_PTR_W     = $clog2(DEPTH);
  localparam int                  c_CNT_W     = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0]  c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [31:0]         c_ALIGN     = 32'hFFFF_FFF0;
  localparam logic [31:0]         c_STRIDE    = 32'd16;

  logic [31:0]        r_pc;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [31:0]        r_mem_pc     [DEPTH];
  logic [127:0]       r_mem_bundle [DEPTH];

  logic w_not_empty;
  logic w_pop;
  logic w_push;

  // Handshake decode: redirect masks valid so decode cannot consume a stale
  // entry in the same cycle it is being flushed. A full FIFO may still accept
  // a push when the head leaves in the same cycle.
  always_comb begin
    w_not_empty  = (r_count != '0);
    bundle_valid = w_not_empty && !redirect_valid;
    w_pop        = bundle_valid && bundle_ready;
    w_push       = fetch_en && !redirect_valid &&
                   ((r_count != c_DEPTH_CNT) || w_pop);
  end

  // Head-of-queue outputs, forced to zero while the queue is empty.
  always_comb begin
    bundle_out = w_not_empty ? r_mem_bundle[r_rd_ptr] : '0;
    bundle_pc  = w_not_empty ? r_mem_pc[r_rd_ptr]     : '0;
  end

  assign pc_out     = r_pc;
  assign fifo_count = r_count;

  // Control state: PC, pointers and occupancy. Redirect wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_pc     <= redirect_pc & c_ALIGN;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + c_STRIDE;
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  // Entry storage: no reset needed, occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]     <= r_pc;
      r_mem_bundle[r_wr_ptr] <= inst_bundle_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit (DEPTH=4,
//                RESET_PC=0). Memory word i holds i+1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic         clk;
  logic         rst;
  logic         fetch_en;
  logic [31:0]  pc_out;
  logic [127:0] inst_bundle_in;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         bundle_valid;
  logic         bundle_ready;
  logic [127:0] bundle_out;
  logic [31:0]  bundle_pc;
  logic [2:0]   fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .pc_out         (pc_out),
    .inst_bundle_in (inst_bundle_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bundle_valid   (bundle_valid),
    .bundle_ready   (bundle_ready),
    .bundle_out     (bundle_out),
    .bundle_pc      (bundle_pc),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word i = i+1, bundle = four consecutive words, MSW first.
  function automatic logic [127:0] mem_bundle(input logic [31:0] p);
    logic [31:0] w;
    w = p >> 2;
    return {w + 32'd1, w + 32'd2, w + 32'd3, w + 32'd4};
  endfunction

  always_comb inst_bundle_in = mem_bundle(pc_out);

  task automatic check(input string tag, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    fetch_en       = 1'b0;
    bundle_ready   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #12;
    // Reset state
    check("rst_pc",    pc_out,       32'h0);
    check("rst_valid", bundle_valid, 1'b0);
    check("rst_out",   bundle_out,   128'h0);
    check("rst_bpc",   bundle_pc,    32'h0);
    check("rst_cnt",   fifo_count,   3'd0);
    rst = 1'b0;

    // Stream with decode always ready
    fetch_en     = 1'b1;
    bundle_ready = 1'b1;
    step();
    check("s0_valid", bundle_valid, 1'b1);
    check("s0_out",   bundle_out,   128'h00000001_00000002_00000003_00000004);
    for (int k = 0; k < 4; k++) begin
      check("s_pc",   pc_out,     32'((k + 1) * 16));
      check("s_bpc",  bundle_pc,  32'(k * 16));
      check("s_bout", bundle_out, mem_bundle(32'(k * 16)));
      check("s_cnt",  fifo_count, 3'd1);
      step();
    end

    // Backpressure from a fresh start
    bundle_ready = 1'b0;
    pulse_reset();
    check("bp_rst_pc", pc_out, 32'h0);
    step(); step(); step(); step();
    check("bp_cnt4", fifo_count, 3'd4);
    check("bp_pc64", pc_out,     32'd64);
    step(); step();
    check("bp_hold_cnt", fifo_count, 3'd4);
    check("bp_hold_pc",  pc_out,     32'd64);
    check("bp_head",     bundle_pc,  32'd0);

    // Full with a simultaneous pop: push and pop together
    bundle_ready = 1'b1;
    step();
    check("fp_cnt",  fifo_count, 3'd4);
    check("fp_pc",   pc_out,     32'd80);
    check("fp_head", bundle_pc,  32'd16);

    // fetch_en low: remaining entries drain in order, then PC frozen
    fetch_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("dr_bpc", bundle_pc,  32'(32 + k * 16));
      check("dr_cnt", fifo_count, 3'(3 - k));
    end
    step();
    check("dr_empty_valid", bundle_valid, 1'b0);
    check("dr_empty_out",   bundle_out,   128'h0);
    step(); step();
    check("dr_frozen_pc",   pc_out,       32'd80);
    check("dr_still_empty", bundle_valid, 1'b0);

    // Redirect with three entries queued
    fetch_en     = 1'b1;
    bundle_ready = 1'b0;
    step(); step(); step();
    check("rd_pre_cnt", fifo_count, 3'd3);
    check("rd_pre_pc",  pc_out,     32'd128);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_002C;
    bundle_ready   = 1'b1;
    #1;
    check("rd_valid_masked", bundle_valid, 1'b0);
    step();
    redirect_valid = 1'b0;
    check("rd_cnt0", fifo_count, 3'd0);
    check("rd_pc",   pc_out,     32'h20);
    step();
    check("rd_first_bpc",  bundle_pc,    32'h20);
    check("rd_first_out",  bundle_out,   mem_bundle(32'h20));
    check("rd_first_vld",  bundle_valid, 1'b1);
    check("rd_next_pc",    pc_out,       32'h30);

    // Back-to-back redirects: last target wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_pc    = 32'h0000_0207;
    step();
    redirect_valid = 1'b0;
    check("b2b_pc",  pc_out,     32'h200);
    check("b2b_cnt", fifo_count, 3'd0);
    step();
    check("b2b_bpc", bundle_pc,  32'h200);

    // Asynchronous reset between edges with a non-empty FIFO
    bundle_ready = 1'b0;
    step(); step();
    check("ar_pre_cnt", fifo_count, 3'd3);
    #2 rst = 1'b1;
    #1;
    check("ar_pc",    pc_out,       32'h0);
    check("ar_cnt",   fifo_count,   3'd0);
    check("ar_valid", bundle_valid, 1'b0);
    check("ar_out",   bundle_out,   128'h0);
    check("ar_bpc",   bundle_pc,    32'h0);
    #1 rst = 1'b0;

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF0;
    step();
    redirect_valid = 1'b0;
    check("wr_pc",  pc_out,     32'hFFFF_FFF0);
    check("wr_cnt", fifo_count, 3'd0);
    step();
    check("wr_pc0",  pc_out,     32'h0);
    check("wr_bpc",  bundle_pc,  32'hFFFF_FFF0);
    check("wr_bout", bundle_out, mem_bundle(32'hFFFF_FFF0));
    step();
    bundle_ready = 1'b1;
    step();
    check("wr_bpc0",  bundle_pc,  32'h0);
    check("wr_bout0", bundle_out, 128'h00000001_00000002_00000003_00000004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the VLIW core. It drives the bundle-fetch address into main memory's instruction port, then captures the returned 128-bit bundle together with its PC into a small FIFO. It presents bundles to decode with a valid/ready handshake. It also supports flush-and-redirect for branches, jumps and exceptions.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be 16-byte aligned.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- fetch_en  input  1  when high, fetching is allowed; when low, the PC holds and there are no pushes (pops continue).
- pc_out  output  32  bundle address to memory's `pc_in`; always equals the internal PC register.
- inst_bundle_in  input  128  bundle from memory; combinational function of `pc_out`; [127:96] is the word at the PC.
- redirect_valid  input  1  flush the FIFO and load a new PC.
- redirect_pc  input  32  redirect target; bits [3:0] ignored (forced to 0).
- bundle_valid  output  1  head entry available to decode.
- bundle_ready  input  1  decode accepts the head entry.
- bundle_out  output  128  head entry's bundle; 0 when the FIFO is empty.
- bundle_pc  output  32  head entry's PC; 0 when the FIFO is empty.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- State:
  - PC register.
  - DEPTH-entry circular buffer of {pc, bundle}.
  - Read and write pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
- pop = bundle_valid && bundle_ready.
- bundle_valid = (count != 0) && !redirect_valid. This is a combinational gate; decode must not consume in a redirect cycle.
- push = fetch_en && !redirect_valid && (count < DEPTH || pop). Pushing into a full FIFO is allowed when a pop occurs in the same cycle.
- On push:
  - the write entry gets {pc_out, inst_bundle_in};
  - the write pointer advances;
  - PC <= PC + 16, 32-bit modulo (32'hFFFF_FFF0 wraps to 0).
- On pop: the read pointer advances.
- count update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- On redirect_valid:
  - both pointers reset to 0 and count <= 0;
  - PC <= {redirect_pc[31:4], 4'b0};
  - no push or pop that cycle.
- Redirect has priority over fetch_en, push and pop.
- When fetch_en is low, the PC does not advance and no pushes occur; queued entries still drain.
- bundle_out and bundle_pc read the entry at the read pointer, masked to 0 when count == 0.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - PC = RESET_PC, so pc_out = RESET_PC;
  - pointers = 0, count = 0;
  - bundle_valid = 0, bundle_out = 0, bundle_pc = 0, fifo_count = 0;
  - FIFO storage need not be cleared.
- Reset mid-operation discards all queued entries and in-flight state immediately.
- Fetch latency:
  - the bundle read while pc_out = P in cycle N (pushed at the edge ending N) is visible at bundle_out in cycle N+1;
  - bundle_valid rises in N+1 if the FIFO was empty.
- Throughput: one bundle per cycle sustained when decode holds bundle_ready high.
- Redirect timing:
  - a redirect asserted in cycle N makes pc_out = target in N+1;
  - the first target bundle appears at the FIFO head in N+2.
- Full (count == DEPTH) with bundle_ready low: no push; PC holds; pc_out stable.
- Back-to-back redirects: each one re-flushes, and the last target wins.
- Empty with fetch_en low: bundle_valid stays 0 indefinitely.

## Test plan
- **Reset and stream:**
  - Stimulus: RESET_PC=0, memory words 0..15 = i+1, fetch_en=1, bundle_ready=1.
  - Response: pc_out goes 0,16,32,… per cycle; first valid cycle gives bundle_out = 128'h00000001_00000002_00000003_00000004 with bundle_pc=0; then bundle_pc=16 with bundle_out words 5..8.
- **Backpressure:**
  - Stimulus: bundle_ready=0, DEPTH=4.
  - Response: after 4 pushes fifo_count=4 and pc_out=64 holds; raising bundle_ready drains PCs 0,16,32,48 in order with no loss or duplication.
- **Full plus simultaneous pop:**
  - Stimulus: FIFO full, then bundle_ready=1 for 1 cycle.
  - Response: push and pop occur in the same cycle; fifo_count stays 4; pc_out advances 64→80.
- **Redirect:**
  - Stimulus: mid-stream with 3 entries queued, redirect_valid=1 and redirect_pc=32'h0000_002C for 1 cycle.
  - Response: bundle_valid=0 in that cycle; fifo_count=0 next cycle; pc_out=32'h20; the next delivered bundle_pc=32'h20.
- **fetch_en low:**
  - Stimulus: deassert fetch_en with 2 entries queued and ready=1.
  - Response: 2 bundles drain, then bundle_valid=0 and pc_out is frozen.
- **Async reset and wrap:**
  - Stimulus: pulse rst between clock edges while the FIFO is non-empty.
  - Response: all outputs clear immediately.
  - Stimulus: separately, redirect to 32'hFFFF_FFF0.
  - Response: pushed PCs are FFFF_FFF0, then 0.
